// File: rtl/pcie_reset_seq.sv
// pcie_reset_seq: PCIe reset sequencer.
//
// Synchronises and glitch-filters the board PERST#, merges it with a software
// reset request, holds everything in reset until the inputs have been quiet for
// HOLD_CYCLES cycles, and then releases NUM_STAGES active-low resets in index
// order, STAGE_DELAY cycles apart. Stage 0 feeds the hard IP npor.
//
// Ports:
//   clk          fabric clock
//   reset        synchronous active-high block reset
//   perst_n      asynchronous board PERST#, active low
//   sw_reset     synchronous software reset request (level or pulse)
//   pin_perst    synchronised, unfiltered PERST#
//   rst_n        per-stage active-low resets, thermometer-coded from bit 0
//   ready        high when every stage is released (state RUN)
//   state        0 = HOLD, 1 = RELEASE, 2 = RUN
//   reset_count  saturating count of reset events seen outside HOLD

module pcie_reset_seq #(
    parameter int NUM_STAGES    = 3,
    parameter int SYNC_DEPTH    = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_DELAY   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  perst_n,
    input  logic                  sw_reset,
    output logic                  pin_perst,
    output logic [NUM_STAGES-1:0] rst_n,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [7:0]            reset_count
);

    // Each counter only ever needs to hold its terminal value (N-1).
    localparam int FILT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1)   ? $clog2(HOLD_CYCLES)   : 1;
    localparam int DLY_W  = (STAGE_DELAY > 1)   ? $clog2(STAGE_DELAY)   : 1;

    localparam logic [FILT_W-1:0]     FILT_MAX   = FILT_W'(FILTER_CYCLES - 1);
    localparam logic [HOLD_W-1:0]     HOLD_MAX   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DLY_W-1:0]      DLY_MAX    = DLY_W'(STAGE_DELAY - 1);
    localparam logic [NUM_STAGES-1:0] FIRST_MASK = NUM_STAGES'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                state_q;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [FILT_W-1:0]     filt_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [DLY_W-1:0]      dly_cnt;

    logic                  perst_s;
    logic                  perst_trig;
    logic                  trigger;
    logic                  quiet;
    logic [NUM_STAGES-1:0] next_mask;

    assign perst_s    = sync_q[SYNC_DEPTH-1];
    assign pin_perst  = perst_s;
    assign state      = state_q;

    // filt_cnt counts earlier consecutive low samples, so the current low
    // sample completes the run when the counter has reached FILTER_CYCLES-1.
    assign perst_trig = ~perst_s & (filt_cnt == FILT_MAX);
    assign trigger    = perst_trig | sw_reset;

    // The hold uses the raw synchronised pin: any low sample restarts it.
    assign quiet      = perst_s & ~sw_reset;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the block can leave it holding (a latch).
    always_comb begin
        next_mask    = rst_n << 1;
        next_mask[0] = 1'b1;
    end

    // NOTE: reset is synchronous here, so it is simply the highest-priority
    // branch inside the clocked block; there is no reset in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            dly_cnt     <= '0;
            state_q     <= ST_HOLD;
            rst_n       <= '0;
            ready       <= 1'b0;
            reset_count <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every flop
            // samples the pre-edge values, independent of statement order.
            sync_q <= {sync_q[SYNC_DEPTH-2:0], perst_n};

            // The glitch filter runs in every state; it saturates at its
            // terminal value while the pin stays low.
            if (perst_s) begin
                filt_cnt <= '0;
            end else if (filt_cnt != FILT_MAX) begin
                filt_cnt <= filt_cnt + 1'b1;
            end

            case (state_q)
                ST_HOLD: begin
                    rst_n   <= '0;
                    ready   <= 1'b0;
                    dly_cnt <= '0;
                    if (!quiet) begin
                        // A trigger here only restarts the hold; it is not a
                        // new reset event, so reset_count is left alone.
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_MAX) begin
                        hold_cnt <= '0;
                        rst_n    <= FIRST_MASK;
                        if (&FIRST_MASK) begin
                            // Single stage: releasing stage 0 finishes the job.
                            state_q <= ST_RUN;
                            ready   <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                ST_RELEASE, ST_RUN: begin
                    if (trigger) begin
                        // Checked before the release step so that a trigger on
                        // a scheduled release edge wins.
                        state_q  <= ST_HOLD;
                        rst_n    <= '0;
                        ready    <= 1'b0;
                        hold_cnt <= '0;
                        dly_cnt  <= '0;
                        if (reset_count != 8'hFF) begin
                            reset_count <= reset_count + 8'd1;
                        end
                    end else if (state_q == ST_RELEASE) begin
                        if (dly_cnt == DLY_MAX) begin
                            dly_cnt <= '0;
                            rst_n   <= next_mask;
                            if (&next_mask) begin
                                state_q <= ST_RUN;
                                ready   <= 1'b1;
                            end
                        end else begin
                            dly_cnt <= dly_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q  <= ST_HOLD;
                    rst_n    <= '0;
                    ready    <= 1'b0;
                    hold_cnt <= '0;
                    dly_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_reset_seq.sv
// tb_pcie_reset_seq: self-checking bench for pcie_reset_seq (default parameters).
// Expected outputs are scheduled into a queue with the edge at which they must
// appear; each clock step pops and compares the entries that fall due.

module tb_pcie_reset_seq;

    logic       clk;
    logic       reset;
    logic       perst_n;
    logic       sw_reset;
    logic       pin_perst;
    logic [2:0] rst_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] reset_count;

    pcie_reset_seq dut (
        .clk         (clk),
        .reset       (reset),
        .perst_n     (perst_n),
        .sw_reset    (sw_reset),
        .pin_perst   (pin_perst),
        .rst_n       (rst_n),
        .ready       (ready),
        .state       (state),
        .reset_count (reset_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         at;
        logic [2:0] rst_n;
        logic       ready;
        logic [1:0] state;
        logic [7:0] cnt;
    } exp_t;

    // Release profile relative to the last non-quiet edge L.
    typedef struct {
        string      name;
        int         off;
        logic [2:0] rst_n;
        logic       ready;
        logic [1:0] state;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       rel_tbl[$];
    int         edge_cnt = 0;
    int         n_tests  = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt  = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic add_vec(input string name, input int off, input logic [2:0] r,
                           input logic rdy, input logic [1:0] st);
        vec_t v;
        v.name = name; v.off = off; v.rst_n = r; v.ready = rdy; v.state = st;
        rel_tbl.push_back(v);
    endtask

    task automatic expect_at(input string name, input int at, input logic [2:0] r,
                             input logic rdy, input logic [1:0] st, input logic [7:0] cnt);
        exp_t e;
        e.name = name; e.at = at; e.rst_n = r; e.ready = rdy; e.state = st; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic push_release(input string prefix, input int last_busy);
        foreach (rel_tbl[i]) begin
            expect_at({prefix, "_", rel_tbl[i].name}, last_busy + rel_tbl[i].off,
                      rel_tbl[i].rst_n, rel_tbl[i].ready, rel_tbl[i].state, exp_cnt);
        end
    endtask

    task automatic compare_due();
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].at <= edge_cnt) begin
            e = exp_q.pop_front();
            check({e.name, "/rst_n"}, rst_n, e.rst_n);
            check({e.name, "/ready"}, ready, e.ready);
            check({e.name, "/state"}, state, e.state);
            check({e.name, "/count"}, reset_count, e.cnt);
        end
    endtask

    // One clock: outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
        compare_due();
    endtask

    task automatic step_to(input int target);
        while (edge_cnt < target) step();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        check({name, "/pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check({name, "/reached_run"}, ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int t;
        int n;

        add_vec("hold_end", 15, 3'b000, 1'b0, 2'd0);
        add_vec("s0_up",    16, 3'b001, 1'b0, 2'd1);
        add_vec("s0_only",  23, 3'b001, 1'b0, 2'd1);
        add_vec("s1_up",    24, 3'b011, 1'b0, 2'd1);
        add_vec("s1_only",  31, 3'b011, 1'b0, 2'd1);
        add_vec("run",      32, 3'b111, 1'b1, 2'd2);

        // ---- 1. Power-up ------------------------------------------------
        reset = 1'b1; perst_n = 1'b1; sw_reset = 1'b0;
        step();
        check("rst/rst_n", rst_n, 3'b000);
        check("rst/ready", ready, 0);
        check("rst/state", state, 0);
        check("rst/count", reset_count, 0);
        check("rst/pin_perst", pin_perst, 0);
        step_to(5);
        reset = 1'b0;
        p = edge_cnt;
        step();
        check("pwr/pin_perst_e1", pin_perst, 0);
        step();
        check("pwr/pin_perst_e2", pin_perst, 1);
        push_release("pwr", p + 2);
        drain("pwr");

        // ---- 2. Glitch reject, then accepted assertion -----------------
        p = edge_cnt;
        expect_at("glitch3_a", p + 3, 3'b111, 1'b1, 2'd2, exp_cnt);
        expect_at("glitch3_b", p + 6, 3'b111, 1'b1, 2'd2, exp_cnt);
        expect_at("glitch3_c", p + 9, 3'b111, 1'b1, 2'd2, exp_cnt);
        perst_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        perst_n = 1'b1;
        drain("glitch3");

        p = edge_cnt;
        expect_at("perst4_pre", p + 5, 3'b111, 1'b1, 2'd2, exp_cnt);
        exp_cnt = sat_inc(exp_cnt);
        expect_at("perst4_hit", p + 6, 3'b000, 1'b0, 2'd0, exp_cnt);
        perst_n = 1'b0;
        for (int i = 0; i < 4; i++) step();
        perst_n = 1'b1;
        drain("perst4");
        push_release("perst4", p + 6);
        drain("perst4_rel");

        // ---- 3. Software reset pulse from RUN ---------------------------
        exp_cnt = sat_inc(exp_cnt);
        expect_at("sw_pulse", edge_cnt + 1, 3'b000, 1'b0, 2'd0, exp_cnt);
        sw_reset = 1'b1; step(); sw_reset = 1'b0;
        push_release("sw", edge_cnt);
        drain("sw");

        // ---- 4. Trigger while only stage 0 is released ------------------
        exp_cnt = sat_inc(exp_cnt);
        expect_at("mid_pulse", edge_cnt + 1, 3'b000, 1'b0, 2'd0, exp_cnt);
        sw_reset = 1'b1; step(); sw_reset = 1'b0;
        p = edge_cnt;
        expect_at("mid_s0", p + 16, 3'b001, 1'b0, 2'd1, exp_cnt);
        step_to(p + 18);
        exp_cnt = sat_inc(exp_cnt);
        expect_at("mid_trig", p + 19, 3'b000, 1'b0, 2'd0, exp_cnt);
        sw_reset = 1'b1; step(); sw_reset = 1'b0;
        push_release("mid_restart", edge_cnt);
        drain("mid");

        // ---- 4b. Trigger on the edge that would release stage 1 ---------
        exp_cnt = sat_inc(exp_cnt);
        expect_at("race_pulse", edge_cnt + 1, 3'b000, 1'b0, 2'd0, exp_cnt);
        sw_reset = 1'b1; step(); sw_reset = 1'b0;
        p = edge_cnt;
        expect_at("race_s0",  p + 16, 3'b001, 1'b0, 2'd1, exp_cnt);
        expect_at("race_pre", p + 23, 3'b001, 1'b0, 2'd1, exp_cnt);
        step_to(p + 23);
        exp_cnt = sat_inc(exp_cnt);
        expect_at("race_trig", p + 24, 3'b000, 1'b0, 2'd0, exp_cnt);
        sw_reset = 1'b1; step(); sw_reset = 1'b0;
        expect_at("race_hold", p + 25, 3'b000, 1'b0, 2'd0, exp_cnt);
        push_release("race_restart", p + 24);
        drain("race");

        // ---- 5. Level sw_reset in HOLD, then hold restart by PERST# -----
        t = edge_cnt + 1;
        exp_cnt = sat_inc(exp_cnt);
        expect_at("hr_trig",    t,      3'b000, 1'b0, 2'd0, exp_cnt);
        expect_at("hr_level",   t + 2,  3'b000, 1'b0, 2'd0, exp_cnt);
        expect_at("hr_delayed", t + 18, 3'b000, 1'b0, 2'd0, exp_cnt);
        sw_reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        sw_reset = 1'b0;
        step_to(t + 12);
        perst_n = 1'b0; step(); perst_n = 1'b1;
        push_release("hr", t + 15);
        drain("hr");

        // ---- 6. Saturation, then a reset pulse mid-sequence -------------
        for (int i = 0; i < 300; i++) begin
            wait_run("sat");
            sw_reset = 1'b1; step(); sw_reset = 1'b0;
            exp_cnt = sat_inc(exp_cnt);
        end
        check("sat/count", reset_count, exp_cnt);
        check("sat/count_255", reset_count, 8'd255);
        check("sat/ready", ready, 0);

        n = 0;
        while (state !== 2'd1 && n < 200) begin
            step();
            n++;
        end
        check("sat/reached_release", state, 1);
        reset = 1'b1; step(); reset = 1'b0;
        exp_cnt = 8'd0;
        check("rstpulse/rst_n", rst_n, 3'b000);
        check("rstpulse/ready", ready, 0);
        check("rstpulse/state", state, 0);
        check("rstpulse/count", reset_count, 0);
        check("rstpulse/pin_perst", pin_perst, 0);
        p = edge_cnt;
        step();
        step();
        check("rstpulse/pin_perst_e2", pin_perst, 1);
        push_release("rstpulse", p + 2);
        drain("rstpulse");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
